// File: rtl/alu_wb_stage.sv
// ALU write-back stage: registers one ALU result per cycle, keeps the
// architectural S/V/Z/C flag register and evaluates branch conditions on it.
module alu_wb_stage #(
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [19:0]   alu_bus,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_fupd,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    cond,
  output logic          wb_valid,
  output logic [15:0]   wb_data,
  output logic [RW-1:0] wb_rd,
  output logic          wb_we,
  output logic          flag_s,
  output logic          flag_v,
  output logic          flag_z,
  output logic          flag_c,
  output logic          cond_true
);

  logic          valid_q, valid_d;
  logic [15:0]   data_q, data_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          we_q, we_d;
  // flags_q bit order follows alu_bus[19:16]: {C, Z, V, S}
  logic [3:0]    flags_q, flags_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    flags_d = flags_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = alu_bus[15:0];
        rd_d   = in_rd;
        we_d   = in_we;
        if (in_fupd) begin
          flags_d = alu_bus[19:16];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      flags_q <= flags_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_data  = data_q;
  assign wb_rd    = rd_q;
  assign wb_we    = valid_q & we_q;
  assign flag_s   = flags_q[0];
  assign flag_v   = flags_q[1];
  assign flag_z   = flags_q[2];
  assign flag_c   = flags_q[3];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000: cond_true = flag_z;
      3'b001: cond_true = ~flag_z;
      3'b010: cond_true = flag_s ^ flag_v;
      3'b011: cond_true = flag_z | (flag_s ^ flag_v);
      3'b100: cond_true = flag_c;
      3'b101: cond_true = ~flag_c;
      3'b110: cond_true = 1'b1;
      3'b111: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: the driver pushes expected outputs from a
// behavioural model, a monitor pops and compares one entry per clock.
module tb_alu_wb_stage;

  localparam int RW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [19:0]   alu_bus;
  logic [RW-1:0] in_rd;
  logic          in_we, in_fupd, stall, flush;
  logic [2:0]    cond;
  logic          wb_valid;
  logic [15:0]   wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_we;
  logic          flag_s, flag_v, flag_z, flag_c, cond_true;

  alu_wb_stage #(.RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_bus(alu_bus),
    .in_rd(in_rd), .in_we(in_we), .in_fupd(in_fupd), .stall(stall),
    .flush(flush), .cond(cond), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .flag_s(flag_s), .flag_v(flag_v),
    .flag_z(flag_z), .flag_c(flag_c), .cond_true(cond_true)
  );

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [15:0]   data;
    logic [RW-1:0] rd;
    logic          s, v, z, c;
    logic          ct;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  bit          m_valid, m_we;
  logic [15:0] m_data;
  logic [RW-1:0] m_rd;
  bit          m_s, m_v, m_z, m_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit ref_cond(bit s, bit v, bit z, bit c, logic [2:0] cd);
    bit lt;
    lt = (s != v);
    case (cd)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return lt;
      3'd3: return z || lt;
      3'd4: return c;
      3'd5: return !c;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o = '{wb_valid, wb_we, wb_data, wb_rd, flag_s, flag_v, flag_z, flag_c, cond_true};
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got v=%0b we=%0b d=%h rd=%0d svzc=%0b%0b%0b%0b ct=%0b, want v=%0b we=%0b d=%h rd=%0d svzc=%0b%0b%0b%0b ct=%0b",
               name, got.valid, got.we, got.data, got.rd, got.s, got.v, got.z, got.c, got.ct,
               want.valid, want.we, want.data, want.rd, want.s, want.v, want.z, want.c, want.ct);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_we = 0; m_data = '0; m_rd = '0;
    m_s = 0; m_v = 0; m_z = 0; m_c = 0;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; alu_bus = '0; in_rd = '0; in_we = 0; in_fupd = 0;
    stall = 0; flush = 0; cond = '0;
  endtask

  // One transaction: drive at negedge, predict the post-edge outputs, queue them.
  task automatic step(input bit v, input logic [19:0] b, input logic [RW-1:0] r,
                      input bit we, input bit fu, input bit st, input bit fl,
                      input logic [2:0] cd);
    obs_t e;
    @(negedge clk);
    in_valid = v; alu_bus = b; in_rd = r; in_we = we; in_fupd = fu;
    stall = st; flush = fl; cond = cd;
    if (fl) begin
      m_valid = 0;
    end else if (!st) begin
      if (v) begin
        m_valid = 1; m_data = b[15:0]; m_rd = r; m_we = we;
        if (fu) begin
          m_s = b[16]; m_v = b[17]; m_z = b[18]; m_c = b[19];
        end
      end else begin
        m_valid = 0;
      end
    end
    e = '{m_valid, m_valid && m_we, m_data, m_rd, m_s, m_v, m_z, m_c,
          ref_cond(m_s, m_v, m_z, m_c, cd)};
    exp_q.push_back(e);
    $display("txn v=%0b bus=%h rd=%0d we=%0b fu=%0b st=%0b fl=%0b cond=%0d", v, b, r, we, fu, st, fl, cd);
  endtask

  // monitor: every output cycle the DUT presents one registered result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("wb_out", actual(), exp_q.pop_front());
    end
  end

  initial begin
    obs_t zero_o;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #2;
    for (int c = 0; c < 8; c++) begin
      cond = c[2:0];
      #1;
      zero_o = '{1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0,
                 ref_cond(0, 0, 0, 0, c[2:0])};
      check("reset_state", actual(), zero_o);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // basic capture with Z set
    step(1, 20'h4_0000, 3'd3, 1, 1, 0, 0, 3'b000);
    // capture without flag update
    step(1, 20'h0_8001, 3'd5, 1, 0, 0, 0, 3'b000);
    // three stalled cycles with new data present, then release
    for (int i = 0; i < 3; i++) step(1, 20'hA_BCDE + 20'(i), 3'd6, 0, 1, 1, 0, 3'b001);
    step(1, 20'h2_1357, 3'd1, 1, 1, 0, 0, 3'b010);
    // flush wins over stall and valid data
    step(1, 20'hF_FFFF, 3'd7, 1, 1, 1, 1, 3'b100);
    // set C and leave a valid result in the stage
    step(1, 20'h8_1234, 3'd2, 1, 1, 0, 0, 3'b100);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    zero_o = '{1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ref_cond(0, 0, 0, 0, cond)};
    check("async_reset", actual(), zero_o);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 20'h4_0000, 3'd3, 1, 1, 0, 0, 3'b000);

    // every flag combination against every condition
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fb;
      fb = f[3:0];
      step(1, {fb[0], fb[1], fb[2], fb[3], 16'(f * 257)}, 3'(f), 1, 1, 0, 0, 3'b000);
      for (int c = 0; c < 8; c++) step(0, 20'h0, 3'd0, 0, 0, 0, 0, c[2:0]);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3, 0) != 0, 20'($urandom), 3'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(4, 0) == 0, $urandom_range(7, 0) == 0,
           3'($urandom));
    end

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter RW, default 3, destination register address width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream ALU result on alu_bus is valid this cycle.
REQ-005 alu_bus  input  20  packed ALU result; [15:0] data, [16] S, [17] V, [18] Z, [19] C.
REQ-006 in_rd  input  RW  destination register for the incoming result.
REQ-007 in_we  input  1  incoming result is to be written to the register file.
REQ-008 in_fupd  input  1  incoming result updates the flag register.
REQ-009 stall  input  1  hold the stage; no capture, no flag update.
REQ-010 flush  input  1  discard the stage contents and any incoming result.
REQ-011 cond  input  3  branch condition selector evaluated against the flag register.
REQ-012 wb_valid  output  1  stage holds a valid result.
REQ-013 wb_data  output  16  registered result data.
REQ-014 wb_rd  output  RW  registered destination address.
REQ-015 wb_we  output  1  register-file write strobe.
REQ-016 flag_s, flag_v, flag_z, flag_c  output  1 each  architectural flag register.
REQ-017 cond_true  output  1  selected condition holds on the current flag register.

Function
REQ-018 Capture: on a rising edge with flush=0, stall=0 and in_valid=1, the stage loads wb_data=alu_bus[15:0], wb_rd=in_rd, the internal we bit=in_we, and sets wb_valid=1.
REQ-019 Bubble: on a rising edge with flush=0, stall=0 and in_valid=0, wb_valid clears to 0; wb_data and wb_rd hold their previous values.
REQ-020 Stall: on a rising edge with stall=1 and flush=0, every register, including the flags, holds its value; in_valid is ignored.
REQ-021 Flush priority: on a rising edge with flush=1, wb_valid clears to 0 and the flags hold, regardless of stall and in_valid; the incoming result is lost.
REQ-022 Flag update: the flags load alu_bus[16..19] into S, V, Z, C on exactly those edges where REQ-018 captures and in_fupd=1; otherwise they hold.
REQ-023 wb_we equals wb_valid AND the registered we bit; it is combinational from registers and never depends directly on an input.
REQ-024 Latency: one cycle, from an alu_bus sample to wb_data and the flags; back-to-back valid inputs produce one result per cycle.
REQ-025 cond_true is combinational from the flag register (new flags are visible the cycle after capture).
- 000: Z
- 001: !Z
- 010: S^V
- 011: Z|(S^V)
- 100: C
- 101: !C
- 110: 1
- 111: 0
REQ-026 The stage performs no arithmetic; the data and flag bits pass through unmodified, with no sign or width change.

Reset
REQ-027 While rst_n=0, immediately and independently of clk:
- wb_valid, wb_we, the we bit, wb_data, wb_rd: 0
- flag_s, flag_v, flag_z: 0
- flag_c: 0
REQ-028 Deassertion of rst_n mid-stream restarts the stage empty; a result presented in the first edge after release is captured normally.
REQ-029 With all flags 0 after reset, cond_true equals 1 for cond = 001, 101, 110 and 0 for all other cond values.

Verification
REQ-030 Capture: in_valid=1, alu_bus=20'h4_0000, in_we=1, in_fupd=1, in_rd=3 -> next cycle wb_valid=1, wb_we=1, wb_data=0, wb_rd=3, flag_z=1, and cond_true=1 for cond=000.
REQ-031 Flag hold: capture 20'h0_8001 with in_fupd=0 after REQ-030 -> wb_data=16'h8001, flag_z still 1, flag_s still 0.
REQ-032 Stall: stall=1 for 3 cycles while in_valid=1 with new data -> wb_* outputs and the flags unchanged for all 3 cycles; the first edge after stall=0 captures the data then present.
REQ-033 Flush: flush=1, stall=1, in_valid=1, in_fupd=1, alu_bus=20'hF_FFFF -> next cycle wb_valid=0, wb_we=0, and the flags unchanged.
REQ-034 Async reset: drop rst_n mid-cycle while wb_valid=1 and flag_c=1 -> wb_valid=0 and flag_c=0 before the next clk edge; the first capture after release behaves as in REQ-030.
REQ-035 Conditions: drive each flag combination S,V,Z,C in 0000..1111 and each cond 000..111 -> cond_true matches the REQ-025 table for all 128 combinations.
